// File: rtl/fpu_add_sub_pkg.sv
// Shared types and helpers for the FPU add/sub exponent path.
package fpu_add_sub_pkg;

    typedef enum logic [1:0] {
        ADJ_NORM,
        ADJ_INC,
        ADJ_HOLD
    } adj_mode_e;

    function automatic int exp_max(input int size_exp);
        return (1 << size_exp) - 1;
    endfunction

endpackage

// File: rtl/add_sub_exp_adjust_core.sv
// Exponent adjust core: mode select (carry > hold > normalise) and the
// signed two-extra-bit exponent sum consumed by the classify stage.
module add_sub_exp_adjust_core
    import fpu_add_sub_pkg::*;
#(
    parameter int SIZE_EXP  = 8,
    parameter int SIZE_LOPD = 8
) (
    input  logic                       overflow,
    input  logic                       underflow,
    input  logic [SIZE_LOPD-1:0]       lopd_value,
    input  logic [SIZE_EXP-1:0]        exp_value,
    output logic signed [SIZE_EXP+1:0] sum
);

    localparam int W = SIZE_EXP + 2;

    adj_mode_e    mode;
    logic [W-1:0] ez;
    logic [W-1:0] lz;

    assign ez = W'(exp_value);
    assign lz = W'(lopd_value);

    always_comb begin
        mode = ADJ_NORM;
        if (overflow) begin
            mode = ADJ_INC;
        end else if (underflow) begin
            mode = ADJ_HOLD;
        end
    end

    // Normalise path subtracts lopd as ~lopd + 1 in the widened domain.
    always_comb begin
        sum = '0;
        unique case (mode)
            ADJ_INC:  sum = ez + W'(1);
            ADJ_HOLD: sum = ez;
            default:  sum = ez + (~lz) + W'(1);
        endcase
    end

endmodule

// File: rtl/add_sub_exp_adjust_pipe.sv
// Two-stage exponent adjust with valid/ready, saturation flags and counter.
// Optional macro ADD_SUB_EXP_ZERO_FORCE_EN: zero mantissa forces exponent 0.
module add_sub_exp_adjust_pipe
    import fpu_add_sub_pkg::*;
#(
    parameter int SIZE_EXP  = 8,
    parameter int SIZE_LOPD = 8,
    parameter int SIZE_TAG  = 4,
    parameter int SIZE_CNT  = 16
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_valid,
    output logic                o_ready,
    input  logic                i_overflow,
    input  logic                i_underflow,
    input  logic                i_zero_flag,
    input  logic [SIZE_LOPD-1:0] i_lopd_value,
    input  logic [SIZE_EXP-1:0] i_exp_value,
    input  logic [SIZE_TAG-1:0] i_tag,
    output logic                o_valid,
    input  logic                i_ready,
    output logic [SIZE_EXP-1:0] o_exp_result,
    output logic                o_exp_ovf,
    output logic                o_exp_unf,
    output logic                o_zero,
    output logic [SIZE_TAG-1:0] o_tag,
    input  logic                i_clr_cnt,
    output logic [SIZE_CNT-1:0] o_sat_cnt
);

    localparam int W = SIZE_EXP + 2;
    localparam logic signed [W-1:0] EMAX = W'(exp_max(SIZE_EXP));
    localparam logic signed [W-1:0] ZERO = '0;

    logic                s1_v;
    logic                s2_v;
    logic                s1_en;
    logic                s2_en;
    logic                accept;
    logic                s1_zero;
    logic [SIZE_TAG-1:0] s1_tag;
    logic signed [W-1:0] s1_sum;
    logic signed [W-1:0] core_sum;
    logic [SIZE_EXP-1:0] cls_res;
    logic                cls_ovf;
    logic                cls_unf;
    logic                sat_evt;

    add_sub_exp_adjust_core #(
        .SIZE_EXP  (SIZE_EXP),
        .SIZE_LOPD (SIZE_LOPD)
    ) u_core (
        .overflow   (i_overflow),
        .underflow  (i_underflow),
        .lopd_value (i_lopd_value),
        .exp_value  (i_exp_value),
        .sum        (core_sum)
    );

    assign s2_en   = ~s2_v | i_ready;
    assign s1_en   = ~s1_v | s2_en;
    assign o_ready = s1_en;
    assign accept  = i_valid & o_ready;
    assign o_valid = s2_v;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s1_v    <= 1'b0;
            s1_sum  <= '0;
            s1_zero <= 1'b0;
            s1_tag  <= '0;
        end else if (s1_en) begin
            s1_v <= i_valid;
            if (i_valid) begin
                s1_sum  <= core_sum;
                s1_zero <= i_zero_flag;
                s1_tag  <= i_tag;
            end
        end
    end

    always_comb begin
        cls_res = s1_sum[SIZE_EXP-1:0];
        cls_ovf = 1'b0;
        cls_unf = 1'b0;
        if (s1_sum >= EMAX) begin
            cls_res = '1;
            cls_ovf = 1'b1;
        end else if (s1_sum <= ZERO) begin
            cls_res = '0;
            cls_unf = 1'b1;
        end
`ifdef ADD_SUB_EXP_ZERO_FORCE_EN
        if (s1_zero) begin
            cls_res = '0;
            cls_ovf = 1'b0;
            cls_unf = 1'b0;
        end
`endif
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            s2_v         <= 1'b0;
            o_exp_result <= '0;
            o_exp_ovf    <= 1'b0;
            o_exp_unf    <= 1'b0;
            o_zero       <= 1'b0;
            o_tag        <= '0;
        end else if (s2_en) begin
            s2_v <= s1_v;
            if (s1_v) begin
                o_exp_result <= cls_res;
                o_exp_ovf    <= cls_ovf;
                o_exp_unf    <= cls_unf;
                o_zero       <= s1_zero;
                o_tag        <= s1_tag;
            end
        end
    end

    assign sat_evt = s2_v & i_ready & (o_exp_ovf | o_exp_unf);

    // Clear has priority over a coincident increment.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_sat_cnt <= '0;
        end else if (i_clr_cnt) begin
            o_sat_cnt <= '0;
        end else if (sat_evt && (o_sat_cnt != '1)) begin
            o_sat_cnt <= o_sat_cnt + SIZE_CNT'(1);
        end
    end

endmodule
